// File: rtl/panel_mem_ctrl.sv
// rtl/panel_mem_ctrl.sv - front-panel memory request controller with paged digit entry
// Optional feature: PANEL_AUTOINC_EN bumps the address after a completed read/write.
module panel_mem_ctrl #(
  parameter int ADDR_W  = 25,
  parameter int DATA_W  = 16,
  parameter int SW_W    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key0,
  input  logic              key1,
  input  logic [SW_W-1:0]   sw,
  input  logic              memDone,
  input  logic [DATA_W-1:0] memOut,
  output logic [1:0]        modeOutput,
  output logic [1:0]        stageLevel,
  output logic [7:0]        pageIdx,
  output logic [ADDR_W-1:0] memoryAddress,
  output logic [DATA_W-1:0] ioDataOut,
  output logic [4*SW_W-1:0] displayData,
  output logic              ioDone,
  output logic              err
);
  localparam int DISP_W = 4 * SW_W;
  localparam int AP     = (ADDR_W + DISP_W - 1) / DISP_W;
  localparam int DP     = (DATA_W + DISP_W - 1) / DISP_W;
  localparam int AW_P   = AP * DISP_W;
  localparam int DW_P   = DP * DISP_W;
  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam logic [1:0] M_CLEAR = 2'b00, M_WRITE = 2'b10, M_READ = 2'b01, M_IDLE = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_WRITE, S_READ, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_SHOW
  } state_t;

  state_t            r_state, w_next;
  logic              r_key0_q, r_key0_p, r_key1_q, r_key1_p;
  logic [SW_W-1:0]   r_sw_q, r_sw_p;
  logic              w_k0, w_k1, w_done, w_timeout;
  logic [SW_W-1:0]   w_sw_evt;
  logic [1:0]        r_mode, w_mode_next, r_stage, w_stage_next;
  logic [7:0]        r_page, w_page_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr_next;
  logic [DATA_W-1:0] r_data, w_data_next, r_result, w_result_next;
  logic [AW_P-1:0]   w_addr_pad, w_addr_ext;
  logic [DW_P-1:0]   w_data_pad, w_data_ext, w_res_ext;
  logic [DISP_W-1:0] r_disp, w_disp_next;
  logic              r_io_done, r_err;

  function automatic state_t mode_state(input logic [1:0] m);
    case (m)
      M_WRITE: return S_WRITE;
      M_READ:  return S_READ;
      default: return S_CLEAR;
    endcase
  endfunction

  assign w_k0      = r_key0_q & ~r_key0_p;
  assign w_k1      = r_key1_q & ~r_key1_p;
  assign w_sw_evt  = r_sw_q & ~r_sw_p;
  assign w_done    = (r_state == S_WAIT) && memDone;
  // memDone in the final WAIT cycle beats the timeout
  assign w_timeout = (r_state == S_WAIT) && !memDone && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_page_next = r_page;
    w_mode_next = r_mode;
    case (r_state)
      S_IDLE: if (w_k0) begin
        w_next      = S_CLEAR;
        w_mode_next = M_CLEAR;
      end
      S_CLEAR, S_WRITE, S_READ: begin
        if (w_k0) begin
          case (r_mode)
            M_CLEAR: begin w_next = S_WRITE; w_mode_next = M_WRITE; end
            M_WRITE: begin w_next = S_READ;  w_mode_next = M_READ;  end
            default: begin w_next = S_CLEAR; w_mode_next = M_CLEAR; end
          endcase
        end else if (w_k1) begin
          w_page_next = 8'd0;
          w_next      = (r_state == S_CLEAR) ? S_ISSUE : S_ADDR;
        end
      end
      S_ADDR: begin
        if (w_k0) begin
          w_next      = mode_state(r_mode);
          w_page_next = 8'd0;
        end else if (w_k1) begin
          if (r_page != 8'(AP - 1)) w_page_next = r_page + 8'd1;
          else begin
            w_page_next = 8'd0;
            w_next      = (r_mode == M_WRITE) ? S_DATA : S_ISSUE;
          end
        end
      end
      S_DATA, S_SHOW: begin
        if (w_k0) begin
          w_next      = mode_state(r_mode);
          w_page_next = 8'd0;
        end else if (w_k1) begin
          if (r_page != 8'(DP - 1)) w_page_next = r_page + 8'd1;
          else begin
            w_page_next = 8'd0;
            w_next      = (r_state == S_DATA) ? S_ISSUE : mode_state(r_mode);
          end
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (w_done) begin
          w_page_next = 8'd0;
          w_next      = (r_mode == M_READ) ? S_SHOW : mode_state(r_mode);
        end else if (w_timeout) begin
          w_page_next = 8'd0;
          w_next      = S_SHOW;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Each digit is incremented inside its own nibble of a padded copy; padding bits are dropped,
  // which gives the partial-top-digit wrap and ignores digits beyond the field.
  always_comb begin
    w_addr_pad = '0;
    w_addr_pad[ADDR_W-1:0] = r_addr;
    w_data_pad = '0;
    w_data_pad[DATA_W-1:0] = r_data;
    for (int i = 0; i < SW_W; i++) begin
      if (w_sw_evt[i] && r_state == S_ADDR)
        w_addr_pad[int'(r_page)*DISP_W + 4*i +: 4] = w_addr_pad[int'(r_page)*DISP_W + 4*i +: 4] + 4'd1;
      if (w_sw_evt[i] && r_state == S_DATA)
        w_data_pad[int'(r_page)*DISP_W + 4*i +: 4] = w_data_pad[int'(r_page)*DISP_W + 4*i +: 4] + 4'd1;
    end
    w_addr_next = w_addr_pad[ADDR_W-1:0];
    w_data_next = w_data_pad[DATA_W-1:0];
`ifdef PANEL_AUTOINC_EN
    if (w_done && r_mode != M_CLEAR) w_addr_next = r_addr + ADDR_W'(1);
`endif
    w_result_next = r_result;
    if (w_done)         w_result_next = memOut;
    else if (w_timeout) w_result_next = '1;
  end

  always_comb begin
    w_addr_ext = '0;
    w_addr_ext[ADDR_W-1:0] = w_addr_next;
    w_data_ext = '0;
    w_data_ext[DATA_W-1:0] = w_data_next;
    w_res_ext  = '0;
    w_res_ext[DATA_W-1:0]  = w_result_next;
    w_disp_next  = '0;
    w_stage_next = 2'd0;
    case (w_next)
      S_ADDR: begin
        w_disp_next  = w_addr_ext[int'(w_page_next)*DISP_W +: DISP_W];
        w_stage_next = 2'd1;
      end
      S_DATA: begin
        w_disp_next  = w_data_ext[int'(w_page_next)*DISP_W +: DISP_W];
        w_stage_next = 2'd2;
      end
      S_SHOW: begin
        w_disp_next  = w_res_ext[int'(w_page_next)*DISP_W +: DISP_W];
        w_stage_next = 2'd3;
      end
      S_ISSUE, S_WAIT: begin
        w_disp_next  = r_disp;
        w_stage_next = 2'd3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key0_q <= 1'b0; r_key0_p <= 1'b0; r_key1_q <= 1'b0; r_key1_p <= 1'b0;
      r_sw_q <= '0; r_sw_p <= '0;
      r_mode <= M_IDLE; r_stage <= 2'd0; r_page <= 8'd0; r_cnt <= '0;
      r_addr <= '0; r_data <= '0; r_result <= '0; r_disp <= '0;
      r_io_done <= 1'b0; r_err <= 1'b0;
    end else begin
      r_key0_q <= key0; r_key0_p <= r_key0_q;
      r_key1_q <= key1; r_key1_p <= r_key1_q;
      r_sw_q <= sw; r_sw_p <= r_sw_q;
      r_mode <= w_mode_next; r_stage <= w_stage_next; r_page <= w_page_next;
      r_addr <= w_addr_next; r_data <= w_data_next; r_result <= w_result_next;
      r_disp <= w_disp_next;
      r_io_done <= (w_next == S_ISSUE);
      r_cnt <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
      if (w_next == S_ISSUE) r_err <= 1'b0;
      else if (w_timeout)    r_err <= 1'b1;
    end
  end

  assign modeOutput    = r_mode;
  assign stageLevel    = r_stage;
  assign pageIdx       = r_page;
  assign memoryAddress = r_addr;
  assign ioDataOut     = r_data;
  assign displayData   = r_disp;
  assign ioDone        = r_io_done;
  assign err           = r_err;
endmodule

// File: tb/tb_panel_mem_ctrl.sv
// tb/tb_panel_mem_ctrl.sv - randomized scoreboard bench for panel_mem_ctrl
module tb_panel_mem_ctrl;
  localparam int ADDR_W = 25, DATA_W = 16, SW_W = 4, TIMEOUT = 8, DISP_W = 16, AP = 2, DP = 1;
  localparam longint unsigned AMASK = (64'd1 << ADDR_W) - 1;

  logic clk = 1'b0;
  logic rst, key0, key1, memDone, ioDone, err;
  logic [3:0] sw;
  logic [15:0] memOut, ioDataOut, displayData;
  logic [1:0] modeOutput, stageLevel;
  logic [7:0] pageIdx;
  logic [24:0] memoryAddress;

  panel_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SW_W(SW_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .key0(key0), .key1(key1), .sw(sw), .memDone(memDone), .memOut(memOut),
    .modeOutput(modeOutput), .stageLevel(stageLevel), .pageIdx(pageIdx),
    .memoryAddress(memoryAddress), .ioDataOut(ioDataOut), .displayData(displayData),
    .ioDone(ioDone), .err(err));

  always #5 clk = ~clk;

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct packed {
    logic [1:0]  mode;
    logic [24:0] addr;
    logic [15:0] data;
  } req_t;
  req_t exp_q[$];
  req_t mon_e;
  logic mon_prev_io = 1'b0;

  // Request monitor: every ioDone strobe must match the next expected request.
  always @(negedge clk) begin
    if (ioDone === 1'b1) begin
      check("ioDone_single_cycle", mon_prev_io, 0);
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_ioDone: got request at addr 0x%0h, expected none", memoryAddress);
      end else begin
        mon_e = exp_q.pop_front();
        check("req_mode", modeOutput, mon_e.mode);
        check("req_addr", memoryAddress, mon_e.addr);
        check("req_data", ioDataOut, mon_e.data);
      end
    end
    mon_prev_io <= ioDone;
  end

  // Memory model: answers resp_delay cycles after ioDone; 0 means never.
  int resp_delay = 0;
  logic [15:0] resp_val = 16'h0;
  initial begin
    memDone = 1'b0;
    memOut  = 16'h0;
    forever begin
      @(negedge clk);
      if (ioDone === 1'b1 && resp_delay > 0) begin
        repeat (resp_delay) @(posedge clk);
        #1;
        memDone = 1'b1;
        memOut  = resp_val;
        @(posedge clk);
        #1;
        memDone = 1'b0;
        memOut  = 16'($urandom);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "timeout");
  end

  logic [1:0] m_mode;
  longint unsigned m_addr, m_data;
  logic m_err;

  function automatic longint unsigned inc_digit(input longint unsigned v, input int width, input int pos);
    longint unsigned m, d;
    int k;
    if (pos >= width) return v;
    k = (width - pos < 4) ? width - pos : 4;
    m = (64'd1 << k) - 1;
    d = ((v >> pos) + 1) & m;
    return (v & ~(m << pos)) | (d << pos);
  endfunction

  function automatic longint unsigned page_of(input longint unsigned v, input int p);
    return (v >> (p * DISP_W)) & 64'hFFFF;
  endfunction

  function automatic int mode_idx(input logic [1:0] m);
    case (m)
      2'b00: return 0;
      2'b10: return 1;
      2'b01: return 2;
      default: return -1;
    endcase
  endfunction

  function automatic logic [1:0] mode_code(input int i);
    case (i)
      0: return 2'b00;
      1: return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  task automatic press(input logic k0, input logic k1, input logic [3:0] s);
    @(posedge clk); #1;
    key0 = k0; key1 = k1; sw = s;
    @(posedge clk); #1;
    key0 = 1'b0; key1 = 1'b0; sw = 4'h0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_panel(input string tag, input logic [1:0] stage, input longint unsigned disp);
    check({tag, "_stage"}, stageLevel, stage);
    check({tag, "_display"}, displayData, disp);
    check({tag, "_mode"}, modeOutput, m_mode);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mode"}, modeOutput, 2'b11);
    check({tag, "_stage"}, stageLevel, 0);
    check({tag, "_page"}, pageIdx, 0);
    check({tag, "_addr"}, memoryAddress, 0);
    check({tag, "_data"}, ioDataOut, 0);
    check({tag, "_display"}, displayData, 0);
    check({tag, "_ioDone"}, ioDone, 0);
    check({tag, "_err"}, err, 0);
  endtask

  task automatic enter_field(input bit is_addr, input longint unsigned tgt);
    int width, np, pos, k;
    longint unsigned cur, m;
    logic [3:0] mask;
    bit last_step, combine, advanced;
    width = is_addr ? ADDR_W : DATA_W;
    np    = is_addr ? AP : DP;
    for (int p = 0; p < np; p++) begin
      advanced = 1'b0;
      for (int step = 0; step < 20; step++) begin
        cur = is_addr ? m_addr : m_data;
        mask = 4'h0;
        last_step = 1'b1;
        for (int i = 0; i < 4; i++) begin
          pos = p * DISP_W + 4 * i;
          if (pos < width) begin
            k = (width - pos < 4) ? width - pos : 4;
            m = (64'd1 << k) - 1;
            if (((cur >> pos) & m) != ((tgt >> pos) & m)) begin
              mask[i] = 1'b1;
              if ((((cur >> pos) + 1) & m) != ((tgt >> pos) & m)) last_step = 1'b0;
            end
          end
        end
        if (mask == 4'h0) break;
        if (is_addr && p == AP - 1 && $urandom_range(0, 3) == 0) mask[3] = 1'b1;
        combine = last_step && ($urandom_range(0, 1) == 1);
        press(1'b0, combine, mask);
        for (int i = 0; i < 4; i++)
          if (mask[i]) cur = inc_digit(cur, width, p * DISP_W + 4 * i);
        if (is_addr) m_addr = cur;
        else m_data = cur;
        if (combine) begin
          advanced = 1'b1;
          break;
        end
      end
      if (!advanced) begin
        if (is_addr) check("addr_page_display", displayData, page_of(m_addr, p));
        else check("data_page_display", displayData, page_of(m_data, p));
        check("entry_page_index", pageIdx, p);
        press(1'b0, 1'b1, 4'h0);
      end
    end
  endtask

  task automatic txn(input int sel, input int delay, input logic [15:0] rval);
    longint unsigned taddr, tdata;
    int steps;
    bit ok;
    req_t r;
    if (m_mode == 2'b11) begin
      press(1'b1, 1'b0, 4'h0);
      m_mode = 2'b00;
    end
    steps = (sel - mode_idx(m_mode) + 3) % 3;
    for (int j = 0; j < steps; j++) press(1'b1, 1'b0, 4'h0);
    m_mode = mode_code(sel);
    check_panel("mode_select", 2'd0, 0);
    taddr = longint'($urandom) & AMASK;
    tdata = longint'($urandom_range(0, 16'hFFFF));
    resp_delay = delay;
    resp_val   = rval;
    r.mode = m_mode;
    if (sel == 0) begin
      r.addr = 25'(m_addr); r.data = 16'(m_data);
      exp_q.push_back(r);
      press(1'b0, 1'b1, 4'h0);
    end else begin
      press(1'b0, 1'b1, 4'h0);
      check("enter_addr_stage", stageLevel, 1);
      check("enter_addr_page", pageIdx, 0);
      r.addr = 25'(taddr);
      r.data = (sel == 1) ? 16'(tdata) : 16'(m_data);
      exp_q.push_back(r);
      enter_field(1'b1, taddr);
      if (sel == 1) begin
        check("enter_data_stage", stageLevel, 2);
        enter_field(1'b0, tdata);
      end
    end
    repeat (TIMEOUT + 6) @(posedge clk);
    #1;
    ok = (delay >= 1 && delay <= TIMEOUT);
    if (ok) begin
      m_err = 1'b0;
`ifdef PANEL_AUTOINC_EN
      if (sel != 0) m_addr = (m_addr + 1) & AMASK;
`endif
    end else m_err = 1'b1;
    check("done_err", err, m_err);
    check("done_addr", memoryAddress, m_addr);
    check("done_data", ioDataOut, m_data);
    if (!ok) check_panel("timeout_show", 2'd3, 16'hFFFF);
    else if (sel == 2) check_panel("read_show", 2'd3, rval);
    else check_panel("done_mode", 2'd0, 0);
    if (!ok || sel == 2) begin
      check("show_page", pageIdx, 0);
      press(1'b0, 1'b1, 4'h0);
      check_panel("show_exit", 2'd0, 0);
      check("err_held", err, m_err);
    end
  endtask

  initial begin
    rst = 1'b1; key0 = 1'b0; key1 = 1'b0; sw = 4'h0;
    m_mode = 2'b11; m_addr = 0; m_data = 0; m_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("reset");

    press(1'b1, 1'b0, 4'h0);
    press(1'b1, 1'b0, 4'h0);
    m_mode = 2'b10;
    press(1'b0, 1'b1, 4'h0);
    for (int j = 0; j < 3; j++) begin
      press(1'b0, 1'b0, 4'b0001);
      m_addr = inc_digit(m_addr, ADDR_W, 0);
    end
    check_panel("first_digits", 2'd1, page_of(m_addr, 0));
    check("first_digits_page", pageIdx, 0);
    check("first_digits_addr", memoryAddress, m_addr);

    @(posedge clk); #1;
    sw = 4'b0001;
    repeat (6) @(posedge clk);
    #1;
    sw = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    m_addr = inc_digit(m_addr, ADDR_W, 0);
    check("held_switch_addr", memoryAddress, m_addr);

    press(1'b0, 1'b1, 4'h0);
    check("addr_page1_index", pageIdx, 1);
    for (int j = 0; j < 3; j++) begin
      press(1'b0, 1'b0, 4'b0100);
      m_addr = inc_digit(m_addr, ADDR_W, 24);
      check("top_bit_toggle", memoryAddress[24], (m_addr >> 24) & 1);
      check("top_digit_display", displayData, page_of(m_addr, 1));
    end
    press(1'b0, 1'b0, 4'b1000);
    check("beyond_field_digit", memoryAddress, m_addr);
    press(1'b1, 1'b0, 4'h0);
    check_panel("abort_addr", 2'd0, 0);
    check("abort_addr_kept", memoryAddress, m_addr);
    press(1'b0, 1'b0, 4'b1111);
    check("sw_in_mode_state", memoryAddress, m_addr);

    txn(1, 3, 16'($urandom));
    txn(2, 2, 16'h1234);
    txn(2, 0, 16'($urandom));
    txn(1, TIMEOUT, 16'($urandom));
    txn(0, 1, 16'($urandom));

    press(1'b1, 1'b0, 4'h0);
    m_mode = 2'b10;
    press(1'b0, 1'b1, 4'h0);
    check("combo_addr_stage", stageLevel, 1);
    press(1'b0, 1'b0, 4'b0011);
    m_addr = inc_digit(inc_digit(m_addr, ADDR_W, 0), ADDR_W, 4);
    press(1'b1, 1'b1, 4'h0);
    check_panel("combo_abort", 2'd0, 0);
    check("combo_abort_addr", memoryAddress, m_addr);
    press(1'b0, 1'b1, 4'h0);
    check("reenter_display", displayData, page_of(m_addr, 0));
    press(1'b1, 1'b0, 4'h0);
    check_panel("reenter_abort", 2'd0, 0);

    for (int t = 0; t < 12; t++) begin
      int r;
      r = $urandom_range(0, 9);
      txn($urandom_range(0, 2), (r > TIMEOUT) ? 0 : r, 16'($urandom));
    end

    for (int j = 0; j < (3 - mode_idx(m_mode)) % 3; j++) press(1'b1, 1'b0, 4'h0);
    m_mode = 2'b00;
    begin
      req_t r;
      r.mode = 2'b00; r.addr = 25'(m_addr); r.data = 16'(m_data);
      exp_q.push_back(r);
    end
    resp_delay = 0;
    press(1'b0, 1'b1, 4'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = 2'b11; m_addr = 0; m_data = 0; m_err = 1'b0;
    check_reset("mid_wait_reset");
    repeat (TIMEOUT + 4) @(posedge clk);
    #1;
    check("post_reset_err", err, 0);
    check("post_reset_stage", stageLevel, 0);
    check("post_reset_mode", modeOutput, 2'b11);

    check("pending_requests", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
